// File: rtl/prt_scaler_pkg.sv
// Shared definitions for the scaler timing-generator controller:
// parameter indices, controller states and error codes.
package prt_scaler_pkg;

    localparam logic [3:0] PIX_HTOTAL  = 4'd0;
    localparam logic [3:0] PIX_HWIDTH  = 4'd1;
    localparam logic [3:0] PIX_HSTART  = 4'd2;
    localparam logic [3:0] PIX_HSW     = 4'd3;
    localparam logic [3:0] PIX_VTOTAL  = 4'd4;
    localparam logic [3:0] PIX_VHEIGHT = 4'd5;
    localparam logic [3:0] PIX_VSTART  = 4'd6;
    localparam logic [3:0] PIX_VSW     = 4'd7;

    localparam int NUM_PARAMS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_SETTLE,
        ST_SYNC,
        ST_RUN,
        ST_ERR
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE = 2'd0;
    localparam err_t ERR_HCFG = 2'd1;
    localparam err_t ERR_VCFG = 2'd2;
    localparam err_t ERR_TMO  = 2'd3;

endpackage

// File: rtl/prt_scaler_lib_edge.sv
// Rising-edge detector for a registered, clock-synchronous level.
// The pulse is valid in the cycle the level is first seen high.
module prt_scaler_lib_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/prt_scaler_tg_ctl.sv
// Scaler timing-generator controller: shadows and validates timing,
// streams it to the generator and starts it on a source vsync edge.
module prt_scaler_tg_ctl
    import prt_scaler_pkg::*;
#(
    parameter int P_PPC    = 4,
    parameter int P_SETTLE = 4,
    parameter int P_TMO    = 2000000
) (
    input  logic        CLK_IN,
    input  logic        RST_N_IN,
    input  logic [3:0]  CFG_IDX_IN,
    input  logic [15:0] CFG_DAT_IN,
    input  logic        CFG_WR_IN,
    input  logic        CMD_START_IN,
    input  logic        CMD_STOP_IN,
    input  logic        SRC_VS_IN,
    output logic [3:0]  VPS_IDX_OUT,
    output logic [15:0] VPS_DAT_OUT,
    output logic        VPS_VLD_OUT,
    output logic        CTL_RUN_OUT,
    output logic        STA_BUSY_OUT,
    output logic        STA_LOCK_OUT,
    output logic [1:0]  STA_ERR_OUT
);

    localparam int CW = $clog2(P_TMO + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(P_TMO);
    localparam logic [CW-1:0] TMO_LAST = CW'(P_TMO - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(P_SETTLE - 1);
    localparam logic [15:0]   PPC_MASK = 16'(P_PPC - 1);

    logic [15:0]   r_sh [NUM_PARAMS];
    state_t        r_state;
    err_t          r_err;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_vs;
    logic [3:0]    r_vps_idx;
    logic [15:0]   r_vps_dat;
    logic          r_vps_vld;
    logic          r_run;
    logic          r_busy;
    logic          r_lock;

    state_t        w_nxt;
    err_t          w_err;
    logic [2:0]    w_idx;
    logic          w_vs_rise;
    logic          w_herr;
    logic          w_verr;
    logic          w_wr_ok;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_vs <= 1'b0;
        end else begin
            r_vs <= SRC_VS_IN;
        end
    end

    prt_scaler_lib_edge u_vs_edge (
        .i_clk   (CLK_IN),
        .i_rst_n (RST_N_IN),
        .i_sig   (r_vs),
        .o_rise  (w_vs_rise)
    );

    // P_PPC is a power of two, so the modulo reduces to a low-bit mask
    assign w_herr = (r_sh[PIX_HWIDTH] > r_sh[PIX_HTOTAL])
                 || ((r_sh[PIX_HTOTAL] & PPC_MASK) != 16'd0)
                 || (r_sh[PIX_HTOTAL] == 16'd0);
    assign w_verr = (r_sh[PIX_VHEIGHT] > r_sh[PIX_VTOTAL])
                 || (r_sh[PIX_VTOTAL] == 16'd0);

    assign w_wr_ok = CFG_WR_IN && !CFG_IDX_IN[3]
                  && (r_state == ST_IDLE
                   || r_state == ST_RUN
                   || r_state == ST_ERR);

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_sh[i] <= 16'd0;
            end
        end else if (w_wr_ok) begin
            r_sh[CFG_IDX_IN[2:0]] <= CFG_DAT_IN;
        end
    end

    always_comb begin
        w_nxt = r_state;
        w_err = r_err;
        if (CMD_STOP_IN) begin
            w_nxt = ST_IDLE;
            w_err = ERR_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (CMD_START_IN) w_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_herr) begin
                        w_nxt = ST_ERR;
                        w_err = ERR_HCFG;
                    end else if (w_verr) begin
                        w_nxt = ST_ERR;
                        w_err = ERR_VCFG;
                    end else begin
                        w_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_idx == 3'd7) w_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == SET_LAST) w_nxt = ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_vs_rise) begin
                        w_nxt = ST_RUN;
                    end else if (r_cnt == TMO_LAST) begin
                        w_nxt = ST_ERR;
                        w_err = ERR_TMO;
                    end
                end
                ST_RUN: begin
                    if (CMD_START_IN) w_nxt = ST_CHECK;
                end
                ST_ERR: begin
                    if (CMD_START_IN) begin
                        w_nxt = ST_CHECK;
                        w_err = ERR_NONE;
                    end
                end
                default: begin
                    w_nxt = ST_IDLE;
                    w_err = ERR_NONE;
                end
            endcase
        end
    end

    assign w_idx = (r_state == ST_LOAD) ? r_idx + 3'd1 : 3'd0;

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_state   <= ST_IDLE;
            r_err     <= ERR_NONE;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_vps_vld <= 1'b0;
            r_vps_idx <= 4'd0;
            r_vps_dat <= 16'd0;
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
            r_lock    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_err   <= w_err;
            r_idx   <= w_idx;
            if (w_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_vps_vld <= (w_nxt == ST_LOAD);
            r_vps_idx <= (w_nxt == ST_LOAD) ? {1'b0, w_idx} : 4'd0;
            r_vps_dat <= (w_nxt == ST_LOAD) ? r_sh[w_idx] : 16'd0;
            r_run     <= (w_nxt == ST_RUN);
            r_lock    <= (w_nxt == ST_RUN);
            r_busy    <= (w_nxt == ST_CHECK) || (w_nxt == ST_LOAD)
                      || (w_nxt == ST_SETTLE) || (w_nxt == ST_SYNC);
        end
    end

    assign VPS_IDX_OUT  = r_vps_idx;
    assign VPS_DAT_OUT  = r_vps_dat;
    assign VPS_VLD_OUT  = r_vps_vld;
    assign CTL_RUN_OUT  = r_run;
    assign STA_BUSY_OUT = r_busy;
    assign STA_LOCK_OUT = r_lock;
    assign STA_ERR_OUT  = r_err;

endmodule
